// File: rtl/wb_arb_pkg.sv
// ============================================================================
// wb_arb_pkg : shared types and constants for the Wishbone round-robin arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package wb_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int c_default_timeout = 255;

    // Index increment that wraps at n
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_arbiter_if.sv
// ============================================================================
// wb_arbiter_if : master-side and slave-side Wishbone signals of the arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

interface wb_arbiter_if #(
    parameter int NUM_M = 2,
    parameter int AW    = 32,
    parameter int DW    = 32
);
    logic [NUM_M-1:0]             m_cyc_i;
    logic [NUM_M-1:0]             m_stb_i;
    logic [NUM_M-1:0]             m_we_i;
    logic [NUM_M-1:0][AW-1:0]     m_addr_i;
    logic [NUM_M-1:0][DW/8-1:0]   m_sel_i;
    logic [NUM_M-1:0][DW-1:0]     m_wdata_i;
    logic [NUM_M-1:0]             m_ack_o;
    logic [NUM_M-1:0]             m_err_o;
    logic [NUM_M-1:0]             m_stall_o;
    logic [DW-1:0]                m_rdata_o;

    logic                         s_cyc_o;
    logic                         s_stb_o;
    logic                         s_we_o;
    logic [AW-1:0]                s_addr_o;
    logic [DW/8-1:0]              s_sel_o;
    logic [DW-1:0]                s_wdata_o;
    logic                         s_ack_i;
    logic                         s_err_i;
    logic                         s_stall_i;
    logic [DW-1:0]                s_rdata_i;

    // slave: the arbiter itself, seen as the slave of the masters
    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_sel_i, m_wdata_i,
        output m_ack_o, m_err_o, m_stall_o, m_rdata_o,
        output s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_sel_o, s_wdata_o,
        input  s_ack_i, s_err_i, s_stall_i, s_rdata_i
    );

    // master: the surrounding masters and shared slave device
    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_sel_i, m_wdata_i,
        input  m_ack_o, m_err_o, m_stall_o, m_rdata_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_sel_o, s_wdata_o,
        output s_ack_i, s_err_i, s_stall_i, s_rdata_i
    );

endinterface

`default_nettype wire

// File: rtl/wb_rr_select.sv
// ============================================================================
// wb_rr_select : first active request at or after ptr, wrapping modulo NUM_M
// Rev 1.0
// ============================================================================
`default_nettype none

module wb_rr_select #(
    parameter  int NUM_M = 2,
    localparam int IW    = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
    input  logic [NUM_M-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    idx,
    output logic             valid
);

    localparam logic [IW:0] c_num_m = (IW+1)'(NUM_M);

    logic [2*NUM_M-1:0] req_dbl;
    logic [NUM_M-1:0]   req_rot;
    logic [IW-1:0]      off;
    logic [IW:0]        sum;

    // Rotate so bit 0 is the requester at ptr
    assign req_dbl = {req, req};
    assign req_rot = NUM_M'(req_dbl >> ptr);

    always_comb begin
        off   = '0;
        valid = 1'b0;
        for (int i = NUM_M - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                off   = IW'(i);
                valid = 1'b1;
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= c_num_m) begin
            sum = sum - c_num_m;
        end
        idx = sum[IW-1:0];
    end

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// ============================================================================
// wb_arbiter : round-robin, non-preemptive Wishbone arbiter, NUM_M -> 1 slave
// Optional bus watchdog enabled by macro WB_ARB_TIMEOUT_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_M   = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = c_default_timeout
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    wb_arbiter_if.slave       bus
);

    localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [IW-1:0]     gnt_idx;
    logic [IW-1:0]     gnt_nxt;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     rr_nxt;
    logic [IW-1:0]     rr_inc;
    logic [IW-1:0]     sel_idx;
    logic              sel_valid;
    logic              owner_active;
    logic              slave_quiet;
    logic              timeout_hit;

    logic              s_cyc;
    logic              s_stb;
    logic              s_we;
    logic [NUM_M-1:0]  m_stall;
    logic [NUM_M-1:0]  m_ack;
    logic [NUM_M-1:0]  m_err;

    wb_rr_select #(
        .NUM_M (NUM_M)
    ) u_rr_select (
        .req   (bus.m_cyc_i),
        .ptr   (rr_ptr),
        .idx   (sel_idx),
        .valid (sel_valid)
    );

    assign rr_inc       = IW'(wrap_inc(int'(gnt_idx), NUM_M));
    assign owner_active = (state == GRANT) && bus.m_cyc_i[gnt_idx];
    assign slave_quiet  = !bus.s_ack_i && !bus.s_err_i;

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [7:0] c_wd_limit = 8'(TIMEOUT - 1);

    logic [7:0] wd_cnt;

    // Counts silent cycles of the current grant; the limit cycle itself errs
    assign timeout_hit = owner_active && slave_quiet && (wd_cnt == c_wd_limit);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_cnt <= '0;
        end else if (owner_active && slave_quiet && !timeout_hit) begin
            wd_cnt <= wd_cnt + 8'd1;
        end else begin
            wd_cnt <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            gnt_idx <= '0;
            rr_ptr  <= '0;
        end else begin
            state   <= state_nxt;
            gnt_idx <= gnt_nxt;
            rr_ptr  <= rr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt_idx;
        rr_nxt    = rr_ptr;
        s_cyc     = 1'b0;
        s_stb     = 1'b0;
        s_we      = 1'b0;
        m_stall   = '1;
        m_ack     = '0;
        m_err     = '0;
        case (state)
            IDLE: begin
                if (sel_valid) begin
                    gnt_nxt   = sel_idx;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!owner_active || timeout_hit) begin
                    state_nxt      = IDLE;
                    rr_nxt         = rr_inc;
                    m_err[gnt_idx] = timeout_hit;
                end else begin
                    s_cyc            = 1'b1;
                    s_stb            = bus.m_stb_i[gnt_idx];
                    s_we             = bus.m_we_i[gnt_idx];
                    m_stall[gnt_idx] = bus.s_stall_i;
                    m_ack[gnt_idx]   = bus.s_ack_i;
                    m_err[gnt_idx]   = bus.s_err_i;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.s_cyc_o   = s_cyc;
    assign bus.s_stb_o   = s_stb;
    assign bus.s_we_o    = s_we;
    assign bus.s_addr_o  = bus.m_addr_i[gnt_idx];
    assign bus.s_sel_o   = bus.m_sel_i[gnt_idx];
    assign bus.s_wdata_o = bus.m_wdata_i[gnt_idx];
    assign bus.m_stall_o = m_stall;
    assign bus.m_ack_o   = m_ack;
    assign bus.m_err_o   = m_err;
    assign bus.m_rdata_o = bus.s_rdata_i;

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// ============================================================================
// tb_wb_arbiter : directed scenarios plus randomized traffic against a model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_wb_arbiter;

    localparam int NUM_M   = 3;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 8;
`ifdef WB_ARB_TIMEOUT_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    wb_arbiter_if #(.NUM_M(NUM_M), .AW(AW), .DW(DW)) bus ();

    wb_arbiter #(
        .NUM_M   (NUM_M),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Master i uses address i<<8 so the granted master is visible on s_addr_o
    task automatic quiet_inputs();
        bus.m_cyc_i = '0;
        bus.m_stb_i = '0;
        bus.m_we_i  = '0;
        for (int i = 0; i < NUM_M; i++) begin
            bus.m_addr_i[i]  = 32'(i) << 8;
            bus.m_sel_i[i]   = 4'hF;
            bus.m_wdata_i[i] = 32'h1000_0000 + 32'(i);
        end
        bus.s_ack_i   = 1'b0;
        bus.s_err_i   = 1'b0;
        bus.s_stall_i = 1'b0;
        bus.s_rdata_i = '0;
    endtask

    task automatic test_reset();
        quiet_inputs();
        bus.m_cyc_i   = '1;
        bus.m_stb_i   = '1;
        bus.s_ack_i   = 1'b1;
        bus.s_rdata_i = 32'hA5A5_0001;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.s_cyc_o !== 1'b0) begin errors++; $display("FAIL reset_s_cyc: got %b want 0", bus.s_cyc_o); end
        checks++; if (bus.s_stb_o !== 1'b0) begin errors++; $display("FAIL reset_s_stb: got %b want 0", bus.s_stb_o); end
        checks++; if (bus.m_stall_o !== 3'b111) begin errors++; $display("FAIL reset_m_stall: got %b want 111", bus.m_stall_o); end
        checks++; if (bus.m_ack_o !== 3'b000) begin errors++; $display("FAIL reset_m_ack: got %b want 000", bus.m_ack_o); end
        checks++; if (bus.m_err_o !== 3'b000) begin errors++; $display("FAIL reset_m_err: got %b want 000", bus.m_err_o); end
        checks++; if (bus.m_rdata_o !== 32'hA5A5_0001) begin errors++; $display("FAIL reset_m_rdata: got %h want a5a50001", bus.m_rdata_o); end
        tick();
        quiet_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        quiet_inputs();
        tick();
        bus.m_cyc_i      = 3'b001;
        bus.m_stb_i      = 3'b001;
        bus.m_we_i       = 3'b001;
        bus.m_addr_i[0]  = 32'h0000_0004;
        bus.m_wdata_i[0] = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++; if (bus.s_cyc_o !== 1'b0) begin errors++; $display("FAIL single_latency: s_cyc got %b want 0", bus.s_cyc_o); end
        tick();
        @(negedge clk);
        checks++; if ({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o} !== 3'b111) begin errors++; $display("FAIL single_ctrl: cyc/stb/we got %b want 111", {bus.s_cyc_o, bus.s_stb_o, bus.s_we_o}); end
        checks++; if (bus.s_addr_o !== 32'h0000_0004) begin errors++; $display("FAIL single_addr: got %h want 00000004", bus.s_addr_o); end
        checks++; if (bus.s_wdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_wdata: got %h want deadbeef", bus.s_wdata_o); end
        bus.s_ack_i = 1'b1;
        #1;
        checks++; if (bus.m_ack_o !== 3'b001) begin errors++; $display("FAIL single_ack: got %b want 001", bus.m_ack_o); end
        checks++; if (bus.m_stall_o !== 3'b110) begin errors++; $display("FAIL single_stall: got %b want 110", bus.m_stall_o); end
        tick();
        bus.s_ack_i = 1'b0;
        bus.m_cyc_i = '0;
        @(negedge clk);
        checks++; if (bus.s_cyc_o !== 1'b0) begin errors++; $display("FAIL single_release: s_cyc got %b want 0", bus.s_cyc_o); end
        tick();
    endtask

    task automatic test_contention();
        quiet_inputs();
        bus.m_cyc_i = 3'b011;
        bus.m_stb_i = 3'b011;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.s_cyc_o !== 1'b0) begin errors++; $display("FAIL cont_first_idle: s_cyc got %b want 0", bus.s_cyc_o); end
        tick();
        @(negedge clk);
        checks++; if (bus.s_cyc_o !== 1'b1 || bus.s_addr_o !== 32'h0) begin errors++; $display("FAIL cont_grant0: cyc=%b addr=%h want 1/00000000", bus.s_cyc_o, bus.s_addr_o); end
        checks++; if (bus.m_stall_o !== 3'b110) begin errors++; $display("FAIL cont_stall0: got %b want 110", bus.m_stall_o); end
        tick();
        bus.m_cyc_i = 3'b010;
        tick();
        @(negedge clk);
        checks++; if (bus.s_cyc_o !== 1'b0) begin errors++; $display("FAIL cont_gap: s_cyc got %b want 0", bus.s_cyc_o); end
        tick();
        @(negedge clk);
        checks++; if (bus.s_cyc_o !== 1'b1 || bus.s_addr_o !== 32'h100) begin errors++; $display("FAIL cont_grant1: cyc=%b addr=%h want 1/00000100", bus.s_cyc_o, bus.s_addr_o); end
        checks++; if (bus.m_stall_o !== 3'b101) begin errors++; $display("FAIL cont_stall1: got %b want 101", bus.m_stall_o); end
        quiet_inputs();
        tick();
        tick();
    endtask

    task automatic test_fairness();
        int prev = -1;
        quiet_inputs();
        bus.m_cyc_i = 3'b011;
        bus.m_stb_i = 3'b011;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int t = 0; t < 8; t++) begin
            int waited = 0;
            int who;
            @(negedge clk);
            while (bus.s_cyc_o !== 1'b1 && waited < 20) begin
                tick();
                @(negedge clk);
                waited++;
            end
            checks++; if (waited != 1) begin errors++; $display("FAIL fair_idle_gap: txn %0d waited %0d cycles want 1", t, waited); end
            if (waited >= 20) break;
            who = int'(bus.s_addr_o[15:8]);
            checks++; if (who != t % 2) begin errors++; $display("FAIL fair_order: txn %0d granted %0d want %0d", t, who, t % 2); end
            checks++; if (who == prev) begin errors++; $display("FAIL fair_repeat: txn %0d master %0d granted twice", t, who); end
            prev = who;
            bus.s_ack_i = 1'b1;
            tick();
            bus.s_ack_i     = 1'b0;
            bus.m_cyc_i[who] = 1'b0;
            tick();
            bus.m_cyc_i[who] = 1'b1;
        end
        quiet_inputs();
        tick();
        tick();
    endtask

    task automatic test_stall();
        int stall_cnt = 0;
        quiet_inputs();
        tick();
        bus.m_cyc_i = 3'b001;
        bus.m_stb_i = 3'b001;
        tick();
        for (int k = 0; k < 6; k++) begin
            bus.s_stall_i = (k < 3);
            @(negedge clk);
            if (bus.m_stall_o[0] === 1'b1) stall_cnt++;
            checks++; if (bus.m_stall_o[2:1] !== 2'b11) begin errors++; $display("FAIL stall_others: cycle %0d got %b want 11", k, bus.m_stall_o[2:1]); end
            tick();
        end
        checks++; if (stall_cnt != 3) begin errors++; $display("FAIL stall_count: got %0d want 3", stall_cnt); end
        quiet_inputs();
        tick();
        tick();
    endtask

    task automatic test_timeout();
        quiet_inputs();
        tick();
        bus.m_cyc_i   = 3'b001;
        bus.m_stb_i   = 3'b001;
        bus.s_stall_i = 1'b1;
        tick();
`ifdef WB_ARB_TIMEOUT_EN
        for (int i = 1; i <= TIMEOUT; i++) begin
            logic       exp_cyc;
            logic [2:0] exp_err;
            exp_cyc = (i < TIMEOUT);
            exp_err = (i == TIMEOUT) ? 3'b001 : 3'b000;
            @(negedge clk);
            checks++; if (bus.s_cyc_o !== exp_cyc || bus.m_err_o !== exp_err) begin errors++; $display("FAIL timeout_cycle%0d: cyc=%b err=%b want %b/%b", i, bus.s_cyc_o, bus.m_err_o, exp_cyc, exp_err); end
            tick();
        end
        @(negedge clk);
        checks++; if (bus.s_cyc_o !== 1'b0) begin errors++; $display("FAIL timeout_idle: s_cyc got %b want 0", bus.s_cyc_o); end
        tick();
        @(negedge clk);
        checks++; if (bus.s_cyc_o !== 1'b1) begin errors++; $display("FAIL timeout_regrant: s_cyc got %b want 1", bus.s_cyc_o); end
`else
        begin
            int held = 0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (bus.s_cyc_o === 1'b1 && bus.m_err_o === 3'b000 && bus.m_stall_o[0] === 1'b1) held++;
                tick();
            end
            checks++; if (held != 300) begin errors++; $display("FAIL no_timeout_hold: held %0d cycles want 300", held); end
        end
`endif
        quiet_inputs();
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        quiet_inputs();
        tick();
        bus.m_cyc_i = 3'b010;
        bus.m_stb_i = 3'b010;
        tick();
        tick();
        bus.m_cyc_i = '0;
        tick();
        bus.m_cyc_i = 3'b001;
        bus.m_stb_i = 3'b001;
        tick();
        @(negedge clk);
        checks++; if (bus.s_cyc_o !== 1'b1) begin errors++; $display("FAIL rstmid_pre: s_cyc got %b want 1", bus.s_cyc_o); end
        #2;
        rst_n       = 1'b0;
        bus.s_ack_i = 1'b1;
        #1;
        checks++; if (bus.s_cyc_o !== 1'b0) begin errors++; $display("FAIL rstmid_cyc: got %b want 0", bus.s_cyc_o); end
        checks++; if (bus.m_ack_o !== 3'b000) begin errors++; $display("FAIL rstmid_ack: got %b want 000", bus.m_ack_o); end
        tick();
        bus.s_ack_i = 1'b0;
        bus.m_cyc_i = 3'b110;
        bus.m_stb_i = 3'b110;
        rst_n       = 1'b1;
        @(negedge clk);
        checks++; if (bus.s_cyc_o !== 1'b0) begin errors++; $display("FAIL rstmid_idle: s_cyc got %b want 0", bus.s_cyc_o); end
        tick();
        @(negedge clk);
        checks++; if (bus.s_cyc_o !== 1'b1 || bus.s_addr_o !== 32'h100) begin errors++; $display("FAIL rstmid_ptr: cyc=%b addr=%h want 1/00000100", bus.s_cyc_o, bus.s_addr_o); end
        quiet_inputs();
        tick();
        tick();
    endtask

    // Reference: owner=-1 means bus free; ptr is the next master to favour
    task automatic test_random();
        int owner = -1;
        int ptr   = 0;
        int wd    = 0;
        int ack_pct;
        quiet_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int cyc = 0; cyc < 800 && errors < 20; cyc++) begin
            logic             exp_scyc, exp_stb, exp_we, to_now;
            logic [NUM_M-1:0] exp_stall, exp_ack, exp_err;
            ack_pct = ((cyc / 64) % 2 == 0) ? 35 : 3;
            for (int i = 0; i < NUM_M; i++) begin
                if (bus.m_cyc_i[i]) bus.m_cyc_i[i] = ($urandom_range(0, 5) != 0);
                else                bus.m_cyc_i[i] = ($urandom_range(0, 2) == 0);
                bus.m_stb_i[i]   = ($urandom_range(0, 3) != 0);
                bus.m_we_i[i]    = 1'($urandom_range(0, 1));
                bus.m_addr_i[i]  = (32'(i) << 24) | ($urandom & 32'h00FF_FFFF);
                bus.m_sel_i[i]   = 4'($urandom_range(0, 15));
                bus.m_wdata_i[i] = $urandom;
            end
            bus.s_ack_i   = ($urandom_range(0, 99) < ack_pct);
            bus.s_err_i   = !bus.s_ack_i && ($urandom_range(0, 29) == 0);
            bus.s_stall_i = ($urandom_range(0, 3) == 0);
            bus.s_rdata_i = $urandom;
            @(negedge clk);
            exp_scyc  = 1'b0;
            exp_stb   = 1'b0;
            exp_we    = 1'b0;
            exp_stall = '1;
            exp_ack   = '0;
            exp_err   = '0;
            to_now    = 1'b0;
            if (owner >= 0 && bus.m_cyc_i[owner]) begin
                if (WD_EN && wd == TIMEOUT - 1 && !bus.s_ack_i && !bus.s_err_i) begin
                    to_now         = 1'b1;
                    exp_err[owner] = 1'b1;
                end else begin
                    exp_scyc         = 1'b1;
                    exp_stb          = bus.m_stb_i[owner];
                    exp_we           = bus.m_we_i[owner];
                    exp_stall[owner] = bus.s_stall_i;
                    exp_ack[owner]   = bus.s_ack_i;
                    exp_err[owner]   = bus.s_err_i;
                end
            end
            checks++; if ({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o} !== {exp_scyc, exp_stb, exp_we}) begin errors++; $display("FAIL rand_ctrl @%0d: cyc/stb/we got %b want %b", cyc, {bus.s_cyc_o, bus.s_stb_o, bus.s_we_o}, {exp_scyc, exp_stb, exp_we}); end
            checks++; if (bus.m_stall_o !== exp_stall) begin errors++; $display("FAIL rand_stall @%0d: got %b want %b", cyc, bus.m_stall_o, exp_stall); end
            checks++; if (bus.m_ack_o !== exp_ack) begin errors++; $display("FAIL rand_ack @%0d: got %b want %b", cyc, bus.m_ack_o, exp_ack); end
            checks++; if (bus.m_err_o !== exp_err) begin errors++; $display("FAIL rand_err @%0d: got %b want %b", cyc, bus.m_err_o, exp_err); end
            checks++; if (bus.m_rdata_o !== bus.s_rdata_i) begin errors++; $display("FAIL rand_rdata @%0d: got %h want %h", cyc, bus.m_rdata_o, bus.s_rdata_i); end
            if (exp_scyc) begin
                checks++; if (bus.s_addr_o !== bus.m_addr_i[owner] || bus.s_sel_o !== bus.m_sel_i[owner] || bus.s_wdata_o !== bus.m_wdata_i[owner]) begin errors++; $display("FAIL rand_path @%0d: addr=%h want %h (owner %0d)", cyc, bus.s_addr_o, bus.m_addr_i[owner], owner); end
            end
            @(posedge clk);
            if (owner < 0) begin
                bit found = 1'b0;
                for (int k = 0; k < NUM_M; k++) begin
                    if (!found && bus.m_cyc_i[(ptr + k) % NUM_M]) begin
                        owner = (ptr + k) % NUM_M;
                        found = 1'b1;
                    end
                end
                wd = 0;
            end else if (!bus.m_cyc_i[owner] || to_now) begin
                ptr   = (owner + 1) % NUM_M;
                owner = -1;
                wd    = 0;
            end else begin
                wd = (bus.s_ack_i || bus.s_err_i) ? 0 : wd + 1;
            end
            #1;
        end
        quiet_inputs();
        tick();
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "tb_wb_arbiter stuck");
    end

    initial begin
        rst_n = 1'b0;
        quiet_inputs();
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_stall();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter NUM_M, default 2, number of Wishbone masters sharing one slave (2..4).
REQ-002 Parameter AW, default 32, address width; DW, default 32, data width.
REQ-003 Parameter TIMEOUT, default 255, watchdog limit in cycles (used only with REQ-027).
REQ-004 clk_i  in  1  single clock; all state on rising edge.
REQ-005 rst_ni  in  1  asynchronous active-low reset.
REQ-006 m_cyc_i / m_stb_i / m_we_i  in  NUM_M each  per-master cycle, strobe, write-enable.
REQ-007 m_addr_i  in  NUM_M x AW; m_sel_i  in  NUM_M x DW/8; m_wdata_i  in  NUM_M x DW  per-master request fields.
REQ-008 m_ack_o / m_err_o / m_stall_o  out  NUM_M each  per-master response and stall.
REQ-009 m_rdata_o  out  DW  read data, shared, valid only with the granted master's ack.
REQ-010 s_cyc_o / s_stb_o / s_we_o  out  1 each; s_addr_o  out  AW; s_sel_o  out  DW/8; s_wdata_o  out  DW  slave request.
REQ-011 s_ack_i / s_err_i / s_stall_i  in  1 each; s_rdata_i  in  DW  slave response.

Function
REQ-012 FSM states: IDLE, GRANT; register gnt_idx (log2 NUM_M bits) and round-robin pointer rr_ptr.
REQ-013 IDLE: s_cyc_o=s_stb_o=0; all m_stall_o=1; all m_ack_o=m_err_o=0.
REQ-014 IDLE with any m_cyc_i high: select the first requester at or after rr_ptr (wrapping modulo NUM_M), register gnt_idx, go to GRANT; grant latency exactly 1 cycle.
REQ-015 GRANT: slave request outputs = granted master's inputs, combinationally; granted m_stall_o = s_stall_i; granted m_ack_o/m_err_o = s_ack_i/s_err_i; m_rdata_o = s_rdata_i.
REQ-016 GRANT: non-granted masters see m_stall_o=1, m_ack_o=0, m_err_o=0.
REQ-017 GRANT held while granted m_cyc_i=1, regardless of other requests (no preemption).
REQ-018 Granted m_cyc_i=0: s_cyc_o=0 that cycle, next state IDLE, rr_ptr <= gnt_idx+1 modulo NUM_M.
REQ-019 Each bus release costs one IDLE cycle before the next grant; back-to-back masters alternate fairly.
REQ-020 s_ack_i/s_err_i arriving in IDLE are dropped and not forwarded.
REQ-021 Simultaneous requests in IDLE: rr_ptr alone decides; ties impossible.

Reset
REQ-022 Reset asserted: state=IDLE, gnt_idx=0, rr_ptr=0, watchdog counter=0, immediately, independent of clk_i.
REQ-023 Outputs during/after reset: s_cyc_o=s_stb_o=0, m_stall_o all 1, m_ack_o=m_err_o=0, m_rdata_o=s_rdata_i.
REQ-024 Reset mid-transaction aborts the grant; no ack or err is emitted for the in-flight transfer.

Configuration
REQ-025 Macro WB_ARB_TIMEOUT_EN selects the bus watchdog.
REQ-026 Without WB_ARB_TIMEOUT_EN: no counter; a slave that never responds holds the grant indefinitely.
REQ-027 With WB_ARB_TIMEOUT_EN: an 8-bit counter increments each GRANT cycle with s_cyc_o=1 and s_ack_i=s_err_i=0; clears on ack, err or IDLE.
REQ-028 Counter reaching TIMEOUT: granted m_err_o=1 for one cycle, s_cyc_o=0 that cycle, next state IDLE, rr_ptr advances as in REQ-018.

Structure
REQ-029 Package wb_arb_pkg holds the state enum (IDLE, GRANT) and the default timeout constant.
REQ-030 Sub-module wb_rr_select: combinational round-robin first-one finder (request vector, rr_ptr -> index, valid).

Verification
REQ-031 Single master: m_cyc_i=01, write addr 0x04; grant next cycle; s_addr_o=0x04, s_ack_i forwarded to m_ack_o[0] only.
REQ-032 Contention: both cyc high from reset; master 0 granted; after its cyc drops, 1 IDLE cycle, then master 1 granted.
REQ-033 Fairness: both hold requests, 4 transactions each; grant sequence 0,1,0,1,... and no master granted twice in a row.
REQ-034 Stall: s_stall_i=1 for 3 cycles; granted m_stall_o=1 for exactly 3 cycles, other m_stall_o constant 1.
REQ-035 With WB_ARB_TIMEOUT_EN, TIMEOUT=8, slave silent: m_err_o=1 on the 8th stalled cycle, then IDLE; without the macro, grant persists past 300 cycles.
REQ-036 Reset asserted mid-read: s_cyc_o=0 immediately, no m_ack_o, rr_ptr=0 after release.
